// File: rtl/ifmap_pkg.sv
// Shared types and constants for the ifmap framer.
// Flag bit positions and the tagged word layout used by the PE.
package ifmap_pkg;

    localparam int IFM_DATA_WIDTH = 32;
    localparam int IFM_LEN_WIDTH  = 8;
    localparam int START_BIT      = IFM_DATA_WIDTH + 1;
    localparam int END_BIT        = IFM_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } framer_state_t;

    typedef struct packed {
        logic                      start_flag;
        logic                      end_flag;
        logic [IFM_DATA_WIDTH-1:0] payload;
    } tagged_word;

endpackage

// File: rtl/tag_skid_fifo.sv
// Two-entry skid FIFO holding flag-tagged words.
// Pushes into a full FIFO and pops from an empty one are ignored.
module tag_skid_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifmap_framer.sv
// Frames a raw ifmap stream into {start, end, payload} words
// and writes them to the PE circular buffer under back-pressure.
module ifmap_framer
    import ifmap_pkg::*;
#(
    parameter int DATA_WIDTH = IFM_DATA_WIDTH,
    parameter int LEN_WIDTH  = IFM_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  row_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  buf_ready,
    output logic                  write_en,
    output logic [DATA_WIDTH+1:0] out_word,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    framer_state_t         r_state;
    framer_state_t         w_next;
    logic [LEN_WIDTH-1:0]  r_row_len;
    logic [LEN_WIDTH-1:0]  r_row_count;
    logic [LEN_WIDTH-1:0]  r_word_idx;
    logic [LEN_WIDTH-1:0]  r_row_idx;
    logic                  r_done;
    logic                  r_cfg_err;

    logic                  w_cfg_zero;
    logic                  w_accept_cfg;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_first;
    logic                  w_last_in_row;
    logic                  w_last_row;
    logic                  w_frame_end;
    logic                  w_drain_end;
    logic [1:0]            w_count;
    logic [DATA_WIDTH+1:0] w_head;
    logic [DATA_WIDTH+1:0] w_push_word;

    assign w_cfg_zero    = (row_len == '0) || (row_count == '0);
    assign w_accept_cfg  = (r_state == S_IDLE) && start && !w_cfg_zero;
    assign w_in_ready    = (r_state == S_STREAM) && (w_count != 2'd2);
    assign w_push        = in_valid && w_in_ready;
    assign w_pop         = (w_count != 2'd0) && buf_ready;
    assign w_first       = (r_word_idx == '0);
    assign w_last_in_row = (r_word_idx == r_row_len - ONE);
    assign w_last_row    = (r_row_idx == r_row_count - ONE);
    assign w_frame_end   = w_push && w_last_in_row && w_last_row;
    // The skid empties this cycle if its last entry is being written now.
    assign w_drain_end   = (w_count == 2'd0) ||
                           ((w_count == 2'd1) && w_pop);
    assign w_push_word   = {w_first, w_last_in_row, in_data};

    assign in_ready = w_in_ready;
    assign write_en = w_pop;
    assign out_word = w_head;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;

    tag_skid_fifo #(
        .WIDTH (DATA_WIDTH + 2)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_word),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept_cfg) w_next = S_STREAM;
            S_STREAM: if (w_frame_end)  w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_end)  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_row_len   <= '0;
            r_row_count <= '0;
            r_word_idx  <= '0;
            r_row_idx   <= '0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_done    <= (r_state == S_DRAIN) && w_drain_end;
            r_cfg_err <= (r_state == S_IDLE) && start && w_cfg_zero;
            if (w_accept_cfg) begin
                r_row_len   <= row_len;
                r_row_count <= row_count;
                r_word_idx  <= '0;
                r_row_idx   <= '0;
            end else if (w_push) begin
                if (w_last_in_row) begin
                    r_word_idx <= '0;
                    r_row_idx  <= r_row_idx + ONE;
                end else begin
                    r_word_idx <= r_word_idx + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifmap_framer.sv
// Self-checking bench for ifmap_framer: config table plus
// randomized handshakes against a count-based reference model.
module tb_ifmap_framer;
    import ifmap_pkg::*;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] row_len = '0;
    logic [LW-1:0] row_count = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          buf_ready = 1'b0;
    logic          in_ready;
    logic          write_en;
    logic [DW+1:0] out_word;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int vectors = 0;
    int miscompares = 0;

    ifmap_framer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_len   (row_len),
        .row_count (row_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .buf_ready (buf_ready),
        .write_en  (write_en),
        .out_word  (out_word),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int cnt;
        int mode;
        int exp_err;
        int exp_writes;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // mode bits: 0 random buf_ready, 1 random in_valid,
    // 2 buf_ready low for 5 cycles, 3 start pulses while busy
    task automatic run_frame(input int len, input int cnt,
                             input int mode, input int exp_err,
                             input int exp_writes);
        int total;
        int acc;
        int wr;
        int cyc;
        bit done_due;
        bit finished;
        logic exp_ir;
        logic exp_we;
        tagged_word tw;
        tagged_word expq[$];

        total = len * cnt;
        acc = 0;
        wr = 0;
        cyc = 0;
        done_due = 0;
        finished = 0;

        @(negedge clk);
        start = 1'b1;
        row_len = LW'(len);
        row_count = LW'(cnt);
        in_valid = 1'b0;
        buf_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err", cfg_err, exp_err);
        chk("busy_after_start", busy, exp_err == 0);

        if (exp_err != 0) begin
            repeat (3) begin
                @(negedge clk);
                #1;
                chk("err_write_en", write_en, 0);
                chk("err_busy", busy, 0);
                chk("err_pulse_once", cfg_err, 0);
            end
            return;
        end

        while (!finished) begin
            if (cyc > 4000) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: frame %0dx%0d stuck", len, cnt);
                break;
            end
            start = 1'b0;
            in_valid = (mode & 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data = $urandom;
            buf_ready = (mode & 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if ((mode & 4) && cyc >= 3 && cyc < 8) buf_ready = 1'b0;
            if ((mode & 8) && cyc == 4) begin
                start = 1'b1;
                row_len = '0;
                row_count = LW'(cnt);
            end
            if ((mode & 8) && cyc == 6) begin
                start = 1'b1;
                row_len = 8'd2;
                row_count = 8'd1;
            end
            #1;
            exp_ir = (acc < total) && ((acc - wr) < 2);
            exp_we = ((acc - wr) > 0) && buf_ready;
            chk("in_ready", in_ready, exp_ir);
            chk("write_en", write_en, exp_we);
            chk("done", done, done_due);
            chk("busy", busy, 1);
            chk("cfg_err_quiet", cfg_err, 0);
            if (done_due) begin
                finished = 1;
            end else begin
                if (exp_we && expq.size() > 0) begin
                    tw = expq.pop_front();
                    chk("out_word", out_word, tw);
                    wr++;
                end
                if (in_valid && exp_ir) begin
                    tw.start_flag = (acc % len) == 0;
                    tw.end_flag = (acc % len) == (len - 1);
                    tw.payload = in_data;
                    expq.push_back(tw);
                    acc++;
                end
                done_due = exp_we && (wr == total);
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("writes", wr, exp_writes);
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{8, 2, 0, 0, 16});
        tbl.push_back('{1, 3, 0, 0, 3});
        tbl.push_back('{0, 4, 0, 1, 0});
        tbl.push_back('{5, 0, 0, 1, 0});
        tbl.push_back('{8, 2, 4, 0, 16});
        tbl.push_back('{6, 2, 8, 0, 12});
        tbl.push_back('{3, 4, 3, 0, 12});
        tbl.push_back('{1, 1, 1, 0, 1});
        tbl.push_back('{255, 1, 3, 0, 255});
        tbl.push_back('{2, 255, 1, 0, 510});
        tbl.push_back('{7, 5, 11, 0, 35});

        rst = 1'b0;
        buf_ready = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b1;
        in_valid = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_frame(tbl[i].len, tbl[i].cnt, tbl[i].mode,
                      tbl[i].exp_err, tbl[i].exp_writes);
        end

        for (int i = 0; i < 6; i++) begin
            int l;
            int c;
            l = $urandom_range(1, 10);
            c = $urandom_range(1, 5);
            run_frame(l, c, 3, 0, l * c);
        end

        // Reset after 3 of 8 words, then a clean frame.
        @(negedge clk);
        start = 1'b1;
        row_len = 8'd8;
        row_count = 8'd1;
        buf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            in_valid = 1'b1;
            in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_write_en", write_en, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_word", out_word, 0);
        run_frame(8, 1, 0, 0, 8);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
